// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU memory arbiter: FSM states and transaction owner.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port.
// Only one transaction is in flight at a time; data requests beat fetches.
//
// state | meaning
// IDLE  | no transaction outstanding; accept data, else inst request
// REQ   | mem_req driven with the latched command until mem_ready
// WAIT  | command accepted; waiting for mem_rvalid to finish it
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [STRB_W-1:0]   cmd_wstrb_q, cmd_wstrb_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                inst_data_ok_q, inst_data_ok_d;
    logic                data_data_ok_q, data_data_ok_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    // Next-state, command latch, response capture and handshake outputs.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cmd_wr_d       = cmd_wr_q;
        cmd_addr_d     = cmd_addr_q;
        cmd_wstrb_d    = cmd_wstrb_q;
        cmd_wdata_d    = cmd_wdata_q;
        inst_data_ok_d = 1'b0;
        data_data_ok_d = 1'b0;
        inst_rdata_d   = inst_rdata_q;
        data_rdata_d   = data_rdata_q;
        inst_addr_ok   = 1'b0;
        data_addr_ok   = 1'b0;
        mem_req        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Acceptance is suppressed while reset is asserted so no
                // handshake is reported for a command that will be dropped.
                if (!rst) begin
                    if (data_req) begin
                        data_addr_ok = 1'b1;
                        owner_d      = OWN_DATA;
                        cmd_wr_d     = data_wr;
                        cmd_addr_d   = data_addr;
                        cmd_wstrb_d  = data_wstrb;
                        cmd_wdata_d  = data_wdata;
                        state_d      = ST_REQ;
                    end else if (inst_req) begin
                        inst_addr_ok = 1'b1;
                        owner_d      = OWN_INST;
                        cmd_wr_d     = 1'b0;
                        cmd_addr_d   = inst_addr;
                        cmd_wstrb_d  = '0;
                        cmd_wdata_d  = '0;
                        state_d      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    if (owner_q == OWN_DATA) begin
                        data_data_ok_d = 1'b1;
                        // A store response carries no data; keep the last load value.
                        if (!cmd_wr_q) begin
                            data_rdata_d = mem_rdata;
                        end
                    end else if (owner_q == OWN_INST) begin
                        inst_data_ok_d = 1'b1;
                        inst_rdata_d   = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_NONE;
            cmd_wr_q       <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_wstrb_q    <= '0;
            cmd_wdata_q    <= '0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            cmd_wr_q       <= cmd_wr_d;
            cmd_addr_q     <= cmd_addr_d;
            cmd_wstrb_q    <= cmd_wstrb_d;
            cmd_wdata_q    <= cmd_wdata_d;
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign mem_wr       = cmd_wr_q;
    assign mem_addr     = cmd_addr_q;
    assign mem_wstrb    = cmd_wstrb_q;
    assign mem_wdata    = cmd_wdata_q;
    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: stimulus pushes expected responses,
// a monitor pops and compares them whenever a data_ok pulse appears.
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   accept_cnt = 0;
    logic auto_resp;
    logic stray_rvalid;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            next();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_lookup = 32'hDEAD_BEEF;
            32'h0000_0200: mem_lookup = 32'h8FA4_0010;
            32'hBFC0_0000: mem_lookup = 32'h3C1D_0000;
            default:       mem_lookup = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Memory model: accept on mem_req & mem_ready, respond the following cycle.
    initial begin : responder
        logic        acc;
        logic        pend;
        logic        pend_stray;
        logic        pend_wr;
        logic [31:0] pend_addr;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            acc = (mem_req === 1'b1) && (mem_ready === 1'b1);
            if (acc) accept_cnt++;
            pend       = acc && auto_resp;
            pend_stray = stray_rvalid;
            pend_wr    = mem_wr;
            pend_addr  = mem_addr;
            @(posedge clk);
            #1;
            mem_rvalid = pend | pend_stray;
            if (pend_stray && !pend) mem_rdata = 32'hBAD0_BAD0;
            else if (pend_wr)        mem_rdata = 32'hFFFF_FFFF;
            else                     mem_rdata = mem_lookup(pend_addr);
        end
    end

    // Monitor: every data_ok pulse must match the oldest expected response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_data_ok", {62'b0, inst_data_ok, data_data_ok}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_owner", {62'b0, inst_data_ok, data_data_ok},
                        e.is_data ? 64'h1 : 64'h2);
                    if (e.is_data) chk("sb_data_rdata", data_rdata, e.rdata);
                    else           chk("sb_inst_rdata", inst_rdata, e.rdata);
                end
            end
        end
    end

    initial begin : stim
        int acc0;
        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_ready = 1'b1; auto_resp = 1'b1; stray_rvalid = 1'b0;

        // Reset: request held during reset must not be acknowledged.
        next(); next();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        @(negedge clk);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        next();
        rst = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        chk("rst_cmd", {mem_wr, mem_wstrb, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);

        // Zero-wait load at 0x100.
        next();
        data_req = 1'b1; data_addr = 32'h100; data_wr = 1'b0;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("ld_c0_data_addr_ok", data_addr_ok, 1);
        chk("ld_c0_inst_addr_ok", inst_addr_ok, 0);
        chk("ld_c0_mem_req", mem_req, 0);
        next();
        data_req = 1'b0;
        @(negedge clk);
        chk("ld_c1_mem_req", mem_req, 1);
        chk("ld_c1_mem_addr", mem_addr, 32'h100);
        chk("ld_c1_mem_wr", mem_wr, 0);
        next();
        @(negedge clk);
        chk("ld_c2_mem_req", mem_req, 0);
        chk("ld_c2_data_ok", data_data_ok, 0);
        next();
        @(negedge clk);
        chk("ld_c3_data_ok", data_data_ok, 1);
        chk("ld_c3_rdata", data_rdata, 32'hDEAD_BEEF);
        next();
        drain("drain_load");

        // Simultaneous requests: data first, fetch accepted at the next IDLE.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_addr = 32'h200; data_wr = 1'b0;
        sb.push_back('{1'b1, 32'h8FA4_0010});
        sb.push_back('{1'b0, 32'h3C1D_0000});
        @(negedge clk);
        chk("both_data_addr_ok", data_addr_ok, 1);
        chk("both_inst_blocked", inst_addr_ok, 0);
        next();
        data_req = 1'b0;
        @(negedge clk);
        chk("both_req_inst_addr_ok", inst_addr_ok, 0);
        chk("both_req_addr", mem_addr, 32'h200);
        next();
        @(negedge clk);
        chk("both_wait_inst_addr_ok", inst_addr_ok, 0);
        next();
        @(negedge clk);
        chk("both_inst_after_data", inst_addr_ok, 1);
        next();
        inst_req = 1'b0;
        @(negedge clk);
        chk("both_inst_mem_addr", mem_addr, 32'hBFC0_0000);
        next();
        drain("drain_both");

        // Store with partial strobes; load data register must not move.
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h500;
        data_wstrb = 4'b0011; data_wdata = 32'h1234_5678;
        sb.push_back('{1'b1, 32'h8FA4_0010});
        @(negedge clk);
        chk("st_data_addr_ok", data_addr_ok, 1);
        next();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
        @(negedge clk);
        chk("st_mem_wr", mem_wr, 1);
        chk("st_mem_wstrb", mem_wstrb, 4'b0011);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("st_mem_addr", mem_addr, 32'h500);
        next();
        drain("drain_store");

        // Backpressure: four stalled REQ cycles, accepted on the fifth.
        mem_ready = 1'b0;
        data_req = 1'b1; data_addr = 32'h300; data_wr = 1'b0;
        sb.push_back('{1'b1, 32'h5A5A_595A});
        acc0 = accept_cnt;
        @(negedge clk);
        chk("bp_data_addr_ok", data_addr_ok, 1);
        next();
        data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_stall_mem_req", mem_req, 1);
            chk("bp_stall_mem_addr", mem_addr, 32'h300);
            chk("bp_stall_inst_addr_ok", inst_addr_ok, 0);
            next();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_mem_req", mem_req, 1);
        next();
        inst_req = 1'b0;
        @(negedge clk);
        chk("bp_wait_mem_req", mem_req, 0);
        chk("bp_single_accept", accept_cnt - acc0, 1);
        next();
        drain("drain_bp");

        // Reset in WAIT, then a stray response: no data_ok, block idle after.
        auto_resp = 1'b0;
        data_req = 1'b1; data_addr = 32'h400; data_wr = 1'b0;
        @(negedge clk);
        chk("rw_data_addr_ok", data_addr_ok, 1);
        next();
        data_req = 1'b0;
        @(negedge clk);
        chk("rw_req_mem_req", mem_req, 1);
        next();
        rst = 1'b1; stray_rvalid = 1'b1;
        @(negedge clk);
        chk("rw_wait_mem_req", mem_req, 0);
        next();
        rst = 1'b0; stray_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_stray_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rw_mem_req", mem_req, 0);
        chk("rw_rdata_cleared", data_rdata, 0);
        next();
        @(negedge clk);
        chk("rw_after_data_ok", {inst_data_ok, data_data_ok}, 0);
        next();
        auto_resp = 1'b1;
        data_req = 1'b1; data_addr = 32'h100; data_wr = 1'b0;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("rw_next_addr_ok", data_addr_ok, 1);
        next();
        data_req = 1'b0;
        drain("drain_after_rst");

        repeat (3) next();
        chk("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
